// File: rtl/mem_access_stage_if.sv
// -----------------------------------------------------------------------------
// mem_access_stage_if
// Data-bus bundle between the MEM pipeline stage and the data memory.
//
// Signals (direction seen from the stage, i.e. the master):
//   bus_req_o    out  1   transfer request, held until bus_ack_i or timeout
//   bus_we_o     out  1   1 = write, 0 = read
//   bus_addr_o   out  32  word-aligned byte address
//   bus_be_o     out  4   byte enables
//   bus_wdata_o  out  32  store data, replicated across lanes
//   bus_ack_i    in   1   transfer complete (read data valid in same cycle)
//   bus_rdata_i  in   32  read data
//
// Modports:
//   master  the MEM stage
//   slave   the memory / bus fabric
// -----------------------------------------------------------------------------
interface mem_access_stage_if;

  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  modport master (
    output bus_req_o,
    output bus_we_o,
    output bus_addr_o,
    output bus_be_o,
    output bus_wdata_o,
    input  bus_ack_i,
    input  bus_rdata_i
  );

  modport slave (
    input  bus_req_o,
    input  bus_we_o,
    input  bus_addr_o,
    input  bus_be_o,
    input  bus_wdata_o,
    output bus_ack_i,
    output bus_rdata_i
  );

endinterface

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// MEM pipeline stage. Takes the EX/MEM register outputs, performs loads and
// stores over a req/ack data bus (alignment check, byte enables, lane
// replication for stores, lane extraction with sign/zero extension for
// loads), stalls the upstream pipeline while a transfer is outstanding, and
// registers the write-back result toward MEM/WB.
//
// Parameters:
//   TIMEOUT_CYCLES  cycles to wait for bus_ack_i before aborting (bus_err_o)
//   CNT_W           timeout counter width, 2**CNT_W > TIMEOUT_CYCLES
//
// Ports:
//   clk_i          in   1   clock, rising edge
//   rst_n_i        in   1   asynchronous active-low reset
//   dmem_ena_i     in   1   instruction performs a memory access
//   dmem_wena_i    in   1   1 = store, 0 = load
//   dmem_type_i    in   2   00 word, 01 half signed, 10 byte signed, 11 byte unsigned
//   alu_result_i   in   32  effective address / pass-through result
//   rt_data_i      in   32  store data
//   rd_waddr_i     in   5   destination register
//   rd_sel_i       in   1   write-back source: 1 = load data, 0 = alu_result_i
//   rd_wena_i      in   1   register write enable
//   bus            master  data bus (see mem_access_stage_if)
//   stall_o        out  1   freeze PC, IF/ID, ID/EX and EX/MEM
//   wb_data_o      out  32  registered write-back data
//   wb_waddr_o     out  5   registered destination register
//   wb_wena_o      out  1   registered write enable
//   misalign_o     out  1   one-cycle pulse: misaligned access dropped
//   bus_err_o      out  1   one-cycle pulse: bus timeout
// -----------------------------------------------------------------------------
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                dmem_ena_i,
  input  logic                dmem_wena_i,
  input  logic [1:0]          dmem_type_i,
  input  logic [31:0]         alu_result_i,
  input  logic [31:0]         rt_data_i,
  input  logic [4:0]          rd_waddr_i,
  input  logic                rd_sel_i,
  input  logic                rd_wena_i,
  mem_access_stage_if.master  bus,
  output logic                stall_o,
  output logic [31:0]         wb_data_o,
  output logic [4:0]          wb_waddr_o,
  output logic                wb_wena_o,
  output logic                misalign_o,
  output logic                bus_err_o
);

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [1:0] TYPE_WORD  = 2'b00;
  localparam logic [1:0] TYPE_HALF  = 2'b01;
  localparam logic [1:0] TYPE_BYTES = 2'b10;
  localparam logic [1:0] TYPE_BYTEU = 2'b11;

  // Last counter value before the transfer is abandoned.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // ---------------------------------------------------------------------------
  // Lane helpers
  // ---------------------------------------------------------------------------

  // Byte enables for the addressed lane(s).
  function automatic logic [3:0] calc_be(input logic [1:0] acc_type,
                                         input logic [1:0] off);
    logic [3:0] be;
    case (acc_type)
      TYPE_WORD: be = 4'b1111;
      TYPE_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      default:   be = 4'b0001 << off;
    endcase
    return be;
  endfunction

  // Store data replicated into every lane so the enabled lane sees it.
  function automatic logic [31:0] calc_wdata(input logic [1:0]  acc_type,
                                             input logic [31:0] data);
    logic [31:0] wd;
    case (acc_type)
      TYPE_WORD: wd = data;
      TYPE_HALF: wd = {2{data[15:0]}};
      default:   wd = {4{data[7:0]}};
    endcase
    return wd;
  endfunction

  // Select the addressed lane of the read word and extend it to 32 bits.
  function automatic logic [31:0] extract_load(input logic [1:0]  acc_type,
                                               input logic [1:0]  off,
                                               input logic [31:0] rdata);
    logic [15:0] half;
    logic [7:0]  byte_v;
    logic [31:0] res;
    half = off[1] ? rdata[31:16] : rdata[15:0];
    case (off)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    case (acc_type)
      TYPE_WORD:  res = rdata;
      TYPE_HALF:  res = {{16{half[15]}}, half};
      TYPE_BYTES: res = {{24{byte_v[7]}}, byte_v};
      TYPE_BYTEU: res = {24'h000000, byte_v};
      default:    res = rdata;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Internal signals
  // ---------------------------------------------------------------------------
  state_t             state_r;
  state_t             state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [1:0]         off_s;
  logic               aligned_s;
  logic               is_idle_s;
  logic               is_busy_s;
  logic               start_s;
  logic               misaligned_s;
  logic               timeout_s;
  logic               stall_s;
  logic [31:0]        load_data_s;
  logic [31:0]        wb_data_r;
  logic [4:0]         wb_waddr_r;
  logic               wb_wena_r;
  logic               misalign_r;
  logic               bus_err_r;

  assign off_s     = alu_result_i[1:0];
  assign is_idle_s = (state_r == ST_IDLE);
  assign is_busy_s = (state_r == ST_BUSY);

  // Alignment rule per access type; byte accesses can never be misaligned.
  always_comb begin
    aligned_s = 1'b1;
    case (dmem_type_i)
      TYPE_WORD: aligned_s = (off_s == 2'b00);
      TYPE_HALF: aligned_s = (off_s[0] == 1'b0);
      default:   aligned_s = 1'b1;
    endcase
  end

  assign start_s      = is_idle_s & dmem_ena_i & aligned_s;
  assign misaligned_s = is_idle_s & dmem_ena_i & ~aligned_s;
  assign timeout_s    = is_busy_s & ~bus.bus_ack_i & (cnt_r == CNT_LAST);

  // Held low during reset so a transfer aborted by reset releases the
  // pipeline at once, even though EX/MEM still presents the memory op.
  assign stall_s = rst_n_i & (start_s | (is_busy_s & ~bus.bus_ack_i & ~timeout_s));
  assign stall_o = stall_s;

  assign load_data_s = extract_load(dmem_type_i, off_s, bus.bus_rdata_i);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: ack wins over timeout in the last waiting cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (dmem_ena_i && aligned_s) begin
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (bus.bus_ack_i || timeout_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Bus outputs: only driven in BUSY; inputs are frozen upstream meanwhile,
  // so the derived address/enables/data stay stable for the whole transfer.
  always_comb begin
    bus.bus_req_o   = 1'b0;
    bus.bus_we_o    = 1'b0;
    bus.bus_addr_o  = 32'h0000_0000;
    bus.bus_be_o    = 4'b0000;
    bus.bus_wdata_o = 32'h0000_0000;
    case (state_r)
      ST_BUSY: begin
        bus.bus_req_o   = 1'b1;
        bus.bus_we_o    = dmem_wena_i;
        bus.bus_addr_o  = {alu_result_i[31:2], 2'b00};
        bus.bus_be_o    = calc_be(dmem_type_i, off_s);
        bus.bus_wdata_o = calc_wdata(dmem_type_i, rt_data_i);
      end
      default: begin
        bus.bus_req_o   = 1'b0;
        bus.bus_we_o    = 1'b0;
        bus.bus_addr_o  = 32'h0000_0000;
        bus.bus_be_o    = 4'b0000;
        bus.bus_wdata_o = 32'h0000_0000;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Timeout counter: cleared on entry to BUSY, saturates instead of wrapping.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (start_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (is_busy_s && !bus.bus_ack_i && !timeout_s && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // ---------------------------------------------------------------------------
  // Write-back registers and error pulses. A stalled edge inserts a bubble
  // (write enable cleared, data/address held).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wb_data_r  <= 32'h0000_0000;
      wb_waddr_r <= 5'd0;
      wb_wena_r  <= 1'b0;
      misalign_r <= 1'b0;
      bus_err_r  <= 1'b0;
    end else begin
      misalign_r <= misaligned_s;
      bus_err_r  <= timeout_s;
      if (!stall_s) begin
        wb_waddr_r <= rd_waddr_i;
        wb_data_r  <= rd_sel_i ? load_data_s : alu_result_i;
        wb_wena_r  <= rd_wena_i & ~misaligned_s & ~timeout_s;
      end else begin
        wb_waddr_r <= wb_waddr_r;
        wb_data_r  <= wb_data_r;
        wb_wena_r  <= 1'b0;
      end
    end
  end

  assign wb_data_o  = wb_data_r;
  assign wb_waddr_o = wb_waddr_r;
  assign wb_wena_o  = wb_wena_r;
  assign misalign_o = misalign_r;
  assign bus_err_o  = bus_err_r;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage. Sits directly downstream of the EX/MEM pipeline register and consumes its outputs.
- Performs loads and stores over a req/ack data bus and applies byte/half/word alignment, sign or zero extension and byte enables.
- Stalls the upstream pipeline while a bus transfer is outstanding.
- Drives registered write-back results toward the MEM/WB stage.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent waiting for bus_ack_i before aborting with bus_err_o.
- CNT_W, 8: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- dmem_ena_i  in  1  instruction performs a memory access.
- dmem_wena_i  in  1  1 = store, 0 = load. Ignored when dmem_ena_i = 0.
- dmem_type_i  in  2  access type: 00 word, 01 half signed, 10 byte signed, 11 byte unsigned.
- alu_result_i  in  32  effective address for memory ops; pass-through result otherwise.
- rt_data_i  in  32  store data.
- rd_waddr_i  in  5  destination register.
- rd_sel_i  in  1  write-back source: 1 = load data, 0 = alu_result_i.
- rd_wena_i  in  1  register write enable.
- bus_req_o  out  1  bus request.
- bus_we_o  out  1  bus write.
- bus_addr_o  out  32  word-aligned address, {alu_result_i[31:2], 2'b00}.
- bus_be_o  out  4  byte enables.
- bus_wdata_o  out  32  replicated store data.
- bus_ack_i  in  1  transfer complete; bus_rdata_i is valid in the same cycle for loads.
- bus_rdata_i  in  32  read data.
- stall_o  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- wb_data_o  out  32  registered write-back data.
- wb_waddr_o  out  5  registered destination register.
- wb_wena_o  out  1  registered write enable.
- misalign_o  out  1  one-cycle pulse: misaligned access dropped.
- bus_err_o  out  1  one-cycle pulse: bus timeout.

Behaviour:
- Reset: asynchronous, active-low. On assertion, state = IDLE, counter = 0, and wb_data_o, wb_waddr_o, wb_wena_o, misalign_o, bus_err_o = 0. Combinational outputs settle to 0 because state = IDLE.
- Reset asserted mid-transfer aborts the transfer immediately; bus_req_o drops without waiting for ack.
- Alignment check: aligned = (type 00: addr[1:0] == 0) or (type 01: addr[0] == 0) or (type 1x: always).
- States: IDLE and BUSY.
- IDLE:
  - If dmem_ena_i & aligned: go to BUSY, clear counter.
  - If dmem_ena_i & ~aligned: stay in IDLE; on the next edge register misalign_o = 1 and wb_wena_o = 0. No bus activity.
  - Otherwise: a non-memory instruction completes this cycle.
- BUSY:
  - bus_req_o = 1. bus_we_o, bus_addr_o, bus_be_o and bus_wdata_o stay stable; upstream is frozen, so the inputs hold.
  - On bus_ack_i: go to IDLE.
  - Else if counter == TIMEOUT_CYCLES - 1: go to IDLE, pulse bus_err_o on the next edge, wb_wena_o = 0.
  - Else: counter increments.
- Request timing: bus_req_o is asserted only in BUSY, so there is one cycle of latency from IDLE to request. Minimum memory-op latency is 2 cycles (ack in the first BUSY cycle).
- stall_o is combinational: (IDLE & dmem_ena_i & aligned) | (BUSY & ~bus_ack_i & ~timeout). On the ack or timeout cycle stall_o = 0, so EX/MEM advances on that same edge.
- Byte enables:
  - word: 1111.
  - half: 0011 << (2 * addr[1]).
  - byte: 0001 << addr[1:0].
- Write data:
  - word: rt_data_i.
  - half: {2{rt_data_i[15:0]}}.
  - byte: {4{rt_data_i[7:0]}}.
- Load extraction: select the lane with addr[1:0] (byte) or addr[1] (half). Type 01 and type 10 sign-extend; type 11 zero-extends.
- Write-back register update, every edge where stall_o = 0:
  - wb_waddr_o <= rd_waddr_i.
  - wb_data_o <= rd_sel_i ? extracted load data : alu_result_i.
  - wb_wena_o <= rd_wena_i & ~misaligned & ~timeout.
- Bubble: on edges where stall_o = 1, wb_wena_o <= 0 and the other wb outputs hold.
- Stores: wb_wena_o follows rd_wena_i, which is expected to be 0.
- Error pulses: misalign_o and bus_err_o are high for exactly one cycle per event.
- Counter behaviour: the counter saturates and never wraps while in BUSY.
- Early ack: bus_ack_i asserted while in IDLE is ignored.

Test Plan:
- Word load at 0x100; ack on the 3rd BUSY cycle with rdata 0xDEADBEEF, rd_sel = 1, rd_wena = 1, rd = 5 -> stall_o high for 3 cycles; next edge wb_data_o = 0xDEADBEEF, wb_waddr_o = 5, wb_wena_o = 1.
- Byte-signed load at 0x103 with rdata 0x80FF_0000 -> wb_data_o = 0xFFFF_FF80. Byte-unsigned at the same address -> 0x0000_0080. Half-signed at 0x102 -> 0xFFFF_80FF.
- Half store at 0x206 with rt = 0x1234ABCD -> bus_addr_o = 0x204, bus_be_o = 1100, bus_wdata_o = 0xABCDABCD, bus_we_o = 1; held stable until ack.
- Word load at 0x101 -> no bus_req_o, stall_o = 0, misalign_o one-cycle pulse, wb_wena_o = 0.
- No ack with TIMEOUT_CYCLES = 4 -> bus_req_o high for exactly 4 cycles, then bus_err_o pulses, stall_o drops, wb_wena_o = 0.
- rst_n_i asserted low in BUSY mid-transfer -> bus_req_o, stall_o and all wb outputs go to 0 immediately; after release, a non-memory op with alu_result 0x55 and rd_wena 1 gives wb_data_o = 0x55 one cycle later.
